// File: rtl/command_frame_pkg.sv
// Shared constants and state encoding for the UART command frame controller.
// Command codes, FSM states and fixed ALU operand register addresses.
package command_frame_pkg;

   localparam logic [7:0] CMD_WRITE   = 8'hAA;
   localparam logic [7:0] CMD_READ    = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      ALU_OPA,
      ALU_OPB,
      ALU_FUN,
      ALU_WAIT,
      TX_SEND,
      TX_WAIT_HIGH,
      TX_WAIT_LOW
   } state_t;

endpackage

// File: rtl/response_sender.sv
// Sends a 1- or 2-byte response over the UART transmit handshake.
// Low byte goes first; each byte waits for busy to rise and then fall.
module response_sender
   import command_frame_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    two_bytes,
   input  logic [2*DATA_WIDTH-1:0] payload,
   input  logic                    tx_busy,
   output logic                    tx_data_valid,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    done
);

   state_t                  state;
   logic [DATA_WIDTH-1:0]   pending;
   logic                    more;

   // Byte sequencing: send, wait busy high, wait busy low, repeat or finish
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= '0;
         more          <= 1'b0;
         tx_data_valid <= 1'b0;
         tx_data       <= '0;
         done          <= 1'b0;
      end else begin
         tx_data_valid <= 1'b0;
         done          <= 1'b0;
         if (abort) begin
            state <= IDLE;
            more  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     tx_data <= payload[DATA_WIDTH-1:0];
                     pending <= payload[2*DATA_WIDTH-1:DATA_WIDTH];
                     more    <= two_bytes;
                     state   <= TX_SEND;
                  end
               end
               TX_SEND: begin
                  if (!tx_busy) begin
                     tx_data_valid <= 1'b1;
                     state         <= TX_WAIT_HIGH;
                  end
               end
               TX_WAIT_HIGH: begin
                  if (tx_busy) state <= TX_WAIT_LOW;
               end
               TX_WAIT_LOW: begin
                  if (!tx_busy) begin
                     if (more) begin
                        tx_data <= pending;
                        more    <= 1'b0;
                        state   <= TX_SEND;
                     end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/command_frame_controller.sv
// Decodes UART command frames into register file and ALU strobes.
// Responses (read data or ALU result) are handed to response_sender.
module command_frame_controller
   import command_frame_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_FUN_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx_data_valid,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic                     rx_error,
   output logic [ADDR_WIDTH-1:0]    rf_address,
   output logic                     rf_write_enable,
   output logic [DATA_WIDTH-1:0]    rf_write_data,
   output logic                     rf_read_enable,
   input  logic [DATA_WIDTH-1:0]    rf_read_data,
   input  logic                     rf_read_data_valid,
   output logic                     alu_enable,
   output logic [ALU_FUN_WIDTH-1:0] alu_function,
   input  logic [2*DATA_WIDTH-1:0]  alu_result,
   input  logic                     alu_result_valid,
   output logic                     tx_data_valid,
   output logic [DATA_WIDTH-1:0]    tx_data,
   input  logic                     tx_busy
);

   state_t                  state;
   logic [2*DATA_WIDTH-1:0] resp;
   logic                    tx_start;
   logic                    tx_two;
   logic                    tx_done;
   logic                    rx_bad;

   assign rx_bad = rx_data_valid & rx_error;

   // Frame decoding; a corrupted byte aborts whatever is in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         rf_address      <= '0;
         rf_write_enable <= 1'b0;
         rf_write_data   <= '0;
         rf_read_enable  <= 1'b0;
         alu_enable      <= 1'b0;
         alu_function    <= '0;
         resp            <= '0;
         tx_start        <= 1'b0;
         tx_two          <= 1'b0;
      end else begin
         rf_write_enable <= 1'b0;
         rf_read_enable  <= 1'b0;
         alu_enable      <= 1'b0;
         tx_start        <= 1'b0;
         if (rx_bad) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (rx_data_valid) begin
                     if (rx_data == DATA_WIDTH'(CMD_WRITE))
                        state <= WR_ADDR;
                     else if (rx_data == DATA_WIDTH'(CMD_READ))
                        state <= RD_ADDR;
                     else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))
                        state <= ALU_OPA;
                     else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP))
                        state <= ALU_FUN;
                  end
               end
               WR_ADDR: begin
                  if (rx_data_valid) begin
                     rf_address <= rx_data[ADDR_WIDTH-1:0];
                     state      <= WR_DATA;
                  end
               end
               WR_DATA: begin
                  if (rx_data_valid) begin
                     rf_write_data   <= rx_data;
                     rf_write_enable <= 1'b1;
                     state           <= IDLE;
                  end
               end
               RD_ADDR: begin
                  if (rx_data_valid) begin
                     rf_address     <= rx_data[ADDR_WIDTH-1:0];
                     rf_read_enable <= 1'b1;
                     state          <= RD_WAIT;
                  end
               end
               RD_WAIT: begin
                  if (rf_read_data_valid) begin
                     resp     <= {{DATA_WIDTH{1'b0}}, rf_read_data};
                     tx_two   <= 1'b0;
                     tx_start <= 1'b1;
                     state    <= TX_SEND;
                  end
               end
               ALU_OPA: begin
                  if (rx_data_valid) begin
                     rf_address      <= ADDR_WIDTH'(OPA_ADDR);
                     rf_write_data   <= rx_data;
                     rf_write_enable <= 1'b1;
                     state           <= ALU_OPB;
                  end
               end
               ALU_OPB: begin
                  if (rx_data_valid) begin
                     rf_address      <= ADDR_WIDTH'(OPB_ADDR);
                     rf_write_data   <= rx_data;
                     rf_write_enable <= 1'b1;
                     state           <= ALU_FUN;
                  end
               end
               ALU_FUN: begin
                  if (rx_data_valid) begin
                     alu_function <= rx_data[ALU_FUN_WIDTH-1:0];
                     alu_enable   <= 1'b1;
                     state        <= ALU_WAIT;
                  end
               end
               ALU_WAIT: begin
                  if (alu_result_valid) begin
                     resp     <= alu_result;
                     tx_two   <= 1'b1;
                     tx_start <= 1'b1;
                     state    <= TX_SEND;
                  end
               end
               TX_SEND: begin
                  if (tx_done) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   response_sender #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_sender (
      .clk           (clk),
      .reset         (reset),
      .start         (tx_start),
      .abort         (rx_bad),
      .two_bytes     (tx_two),
      .payload       (resp),
      .tx_busy       (tx_busy),
      .tx_data_valid (tx_data_valid),
      .tx_data       (tx_data),
      .done          (tx_done)
   );

endmodule

// File: tb/tb_command_frame_controller.sv
// Scoreboard bench for command_frame_controller.
// Expected strobes are queued per frame and matched by a negedge monitor.
module tb_command_frame_controller;

   localparam int EV_WR = 0;
   localparam int EV_RD = 1;
   localparam int EV_ALU = 2;
   localparam int EV_TX = 3;

   typedef struct {
      int         kind;
      logic [3:0] addr;
      logic [7:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_data_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_error = 1'b0;
   logic [3:0]  rf_address;
   logic        rf_write_enable;
   logic [7:0]  rf_write_data;
   logic        rf_read_enable;
   logic [7:0]  rf_read_data = 8'h00;
   logic        rf_read_data_valid = 1'b0;
   logic        alu_enable;
   logic [3:0]  alu_function;
   logic [15:0] alu_result = 16'h0000;
   logic        alu_result_valid = 1'b0;
   logic        tx_data_valid;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int last_tx = -100;
   int rd_lat = 2;
   logic [7:0]  read_value = 8'h00;
   logic [15:0] alu_value = 16'h0000;
   logic        alu_hold = 1'b0;
   logic        prev_any = 1'b0;
   ev_t exp_q[$];

   command_frame_controller dut (
      .clk                (clk),
      .reset              (reset),
      .rx_data_valid      (rx_data_valid),
      .rx_data            (rx_data),
      .rx_error           (rx_error),
      .rf_address         (rf_address),
      .rf_write_enable    (rf_write_enable),
      .rf_write_data      (rf_write_data),
      .rf_read_enable     (rf_read_enable),
      .rf_read_data       (rf_read_data),
      .rf_read_data_valid (rf_read_data_valid),
      .alu_enable         (alu_enable),
      .alu_function       (alu_function),
      .alu_result         (alu_result),
      .alu_result_valid   (alu_result_valid),
      .tx_data_valid      (tx_data_valid),
      .tx_data            (tx_data),
      .tx_busy            (tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file read responder
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && rf_read_enable === 1'b1) begin
            repeat (rd_lat) @(posedge clk);
            #1;
            rf_read_data = read_value;
            rf_read_data_valid = 1'b1;
            @(posedge clk);
            #1;
            rf_read_data_valid = 1'b0;
         end
      end
   end

   // ALU responder
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && alu_enable === 1'b1 && !alu_hold) begin
            repeat (3) @(posedge clk);
            #1;
            alu_result = alu_value;
            alu_result_valid = 1'b1;
            @(posedge clk);
            #1;
            alu_result_valid = 1'b0;
         end
      end
   end

   // UART transmitter model: busy for six cycles after a request
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && tx_data_valid === 1'b1) begin
            @(posedge clk);
            #1;
            tx_busy = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            tx_busy = 1'b0;
         end
      end
   end

   // Strobe monitor against the expected-event queue
   always @(negedge clk) begin
      int k;
      int n;
      logic [3:0] oa;
      logic [7:0] od;
      ev_t e;
      k = -1;
      oa = 4'h0;
      od = 8'h00;
      n = int'(rf_write_enable === 1'b1) + int'(rf_read_enable === 1'b1)
        + int'(alu_enable === 1'b1) + int'(tx_data_valid === 1'b1);
      if (!reset) begin
         if (rf_write_enable === 1'b1) begin
            k = EV_WR; oa = rf_address; od = rf_write_data;
         end else if (rf_read_enable === 1'b1) begin
            k = EV_RD; oa = rf_address;
         end else if (alu_enable === 1'b1) begin
            k = EV_ALU; od = {4'h0, alu_function};
         end else if (tx_data_valid === 1'b1) begin
            k = EV_TX; od = tx_data;
         end
         if (k >= 0) begin
            compared++;
            if (n != 1 || prev_any) begin
               mismatched++;
               $display("FAIL strobe_overlap: strobes=%0d prev=%0b required 1 and 0",
                        n, prev_any);
            end
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_strobe: kind=%0d addr=%h data=%h required none",
                        k, oa, od);
            end else begin
               e = exp_q.pop_front();
               if (e.kind !== k || e.addr !== oa || e.data !== od) begin
                  mismatched++;
                  $display("FAIL event: got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                           k, oa, od, e.kind, e.addr, e.data);
               end
            end
            if (k == EV_TX) begin
               compared++;
               if (tx_busy !== 1'b0 || cyc - last_tx < 8) begin
                  mismatched++;
                  $display("FAIL tx_pacing: busy=%b gap=%0d required busy=0 gap>=8",
                           tx_busy, cyc - last_tx);
               end
               last_tx = cyc;
            end
         end
      end
      prev_any = (n != 0);
   end

   task automatic push(input int kind, input logic [3:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
      @(posedge clk);
      #1;
      rx_data_valid = 1'b1;
      rx_data = b;
      rx_error = err;
      @(posedge clk);
      #1;
      rx_data_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL %s_timeout: pending=%0d required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if ({rf_write_enable, rf_read_enable, alu_enable, tx_data_valid} !== 4'b0) begin
         mismatched++;
         $display("FAIL reset_strobes: got %b required 0000",
                  {rf_write_enable, rf_read_enable, alu_enable, tx_data_valid});
      end
      compared++;
      if (rf_address !== 4'h0 || alu_function !== 4'h0) begin
         mismatched++;
         $display("FAIL reset_addr_fun: got %h/%h required 0/0", rf_address, alu_function);
      end
      compared++;
      if (rf_write_data !== 8'h00 || tx_data !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_data: got %h/%h required 00/00", rf_write_data, tx_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_write();
      push(EV_WR, 4'h5, 8'h3C);
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h3C);
      drain("write", 50);
   endtask

   task automatic test_read();
      rd_lat = 2;
      read_value = 8'h5A;
      push(EV_RD, 4'h7, 8'h00);
      push(EV_TX, 4'h0, 8'h5A);
      send_byte(8'hBB);
      send_byte(8'h07);
      drain("read", 100);
   endtask

   task automatic test_alu_ops();
      alu_value = 16'h1234;
      push(EV_WR, 4'h0, 8'h10);
      push(EV_WR, 4'h1, 8'h20);
      push(EV_ALU, 4'h0, 8'h02);
      push(EV_TX, 4'h0, 8'h34);
      push(EV_TX, 4'h0, 8'h12);
      send_byte(8'hCC);
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h02);
      drain("alu_cc", 150);
   endtask

   task automatic test_error_abort();
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h11, 1'b1);
      repeat (5) @(negedge clk);
      push(EV_WR, 4'h3, 8'h11);
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h11);
      drain("error_abort", 50);
   endtask

   task automatic test_garbage_reset();
      send_byte(8'h55);
      alu_hold = 1'b1;
      push(EV_ALU, 4'h0, 8'h01);
      send_byte(8'hDD);
      send_byte(8'h01);
      drain("alu_dd", 50);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++;
      if ({rf_write_enable, rf_read_enable, alu_enable, tx_data_valid} !== 4'b0
          || rf_address !== 4'h0 || rf_write_data !== 8'h00
          || alu_function !== 4'h0 || tx_data !== 8'h00) begin
         mismatched++;
         $display("FAIL midframe_reset: addr=%h wd=%h fun=%h txd=%h required all 0",
                  rf_address, rf_write_data, alu_function, tx_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      alu_hold = 1'b0;
      #1;
      alu_result_valid = 1'b1;
      alu_result = 16'hBEEF;
      @(posedge clk);
      #1;
      alu_result_valid = 1'b0;
      repeat (30) @(negedge clk);
      alu_value = 16'hA55A;
      push(EV_ALU, 4'h0, 8'h03);
      push(EV_TX, 4'h0, 8'h5A);
      push(EV_TX, 4'h0, 8'hA5);
      send_byte(8'hDD);
      send_byte(8'h03);
      drain("alu_after_reset", 150);
   endtask

   task automatic test_drop_in_wait();
      rd_lat = 12;
      read_value = 8'hC3;
      push(EV_RD, 4'h9, 8'h00);
      push(EV_TX, 4'h0, 8'hC3);
      send_byte(8'hBB);
      send_byte(8'hF9);
      send_byte(8'hAA);
      send_byte(8'h0E);
      drain("read_drop", 150);
      rd_lat = 2;
      push(EV_WR, 4'h9, 8'h77);
      send_byte(8'hAA);
      send_byte(8'h09);
      send_byte(8'h77);
      drain("write_after_drop", 50);
   endtask

   task automatic test_back_to_back();
      read_value = 8'h81;
      push(EV_WR, 4'hF, 8'hE1);
      push(EV_RD, 4'hF, 8'h00);
      push(EV_TX, 4'h0, 8'h81);
      send_byte(8'hAA);
      send_byte(8'h0F);
      send_byte(8'hE1);
      send_byte(8'hBB);
      send_byte(8'h0F);
      drain("back_to_back", 150);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_alu_ops();
      test_error_abort();
      test_garbage_reset();
      test_drop_in_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/command_frame_controller.md
COMMAND_FRAME_CONTROLLER -- requirements
Module: command_frame_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the byte width of UART payloads and the register file.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, the register file address width.
REQ-003 The block SHALL have parameter ALU_FUN_WIDTH, default 4, the ALU function code width.
REQ-004 The block SHALL have these ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high reset.
rx_data_valid  in  1  one-cycle pulse from the UART receiver marking a byte.
rx_data  in  DATA_WIDTH  received byte, qualified by rx_data_valid.
rx_error  in  1  parity or frame error for the byte, qualified by rx_data_valid.
rf_address  out  ADDR_WIDTH  register file address.
rf_write_enable  out  1  one-cycle write strobe.
rf_write_data  out  DATA_WIDTH  write data.
rf_read_enable  out  1  one-cycle read strobe.
rf_read_data  in  DATA_WIDTH  read data.
rf_read_data_valid  in  1  read data qualifier.
alu_enable  out  1  one-cycle ALU start strobe.
alu_function  out  ALU_FUN_WIDTH  ALU operation code.
alu_result  in  2*DATA_WIDTH  ALU result.
alu_result_valid  in  1  ALU result qualifier.
tx_data_valid  out  1  one-cycle byte request to the UART transmitter.
tx_data  out  DATA_WIDTH  byte to transmit.
tx_busy  in  1  UART transmitter busy.

Function
REQ-005 The block SHALL accept the following frames:
- 0xAA: write frame, bytes addr, data.
- 0xBB: read frame, byte addr; response is 1 byte.
- 0xCC: ALU-with-operands frame, bytes opA, opB, fun; response is 2 bytes.
- 0xDD: ALU-no-operand frame, byte fun; response is 2 bytes.
REQ-006 The state machine SHALL have states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_SEND, TX_WAIT_HIGH, TX_WAIT_LOW, and SHALL reset to IDLE.
REQ-007 In IDLE, an rx_data_valid byte that is not 0xAA, 0xBB, 0xCC or 0xDD SHALL be discarded, and the block SHALL stay in IDLE.
REQ-008 A byte with rx_data_valid=1 and rx_error=1 SHALL be discarded in any state, and the block SHALL abort any partial frame and return to IDLE with no strobe issued.
REQ-009 Write frame: in the cycle after the data byte is accepted, the block SHALL drive rf_write_enable=1 for 1 cycle, with rf_address=addr[ADDR_WIDTH-1:0] and rf_write_data=data, then return to IDLE.
REQ-010 Read frame: in the cycle after the addr byte is accepted, the block SHALL drive rf_read_enable=1 for 1 cycle, then wait in RD_WAIT for rf_read_data_valid, latch rf_read_data, and send it as 1 byte.
REQ-011 0xCC frame: the block SHALL write opA to address 0 and opB to address 1, each with a 1-cycle rf_write_enable in the cycle after that byte is accepted.
REQ-012 0xCC and 0xDD frames: in the cycle after the fun byte is accepted, the block SHALL drive alu_enable=1 for 1 cycle with alu_function=fun[ALU_FUN_WIDTH-1:0]; it SHALL then wait in ALU_WAIT for alu_result_valid and latch alu_result.
REQ-013 The ALU response SHALL be sent as 2 bytes: result[DATA_WIDTH-1:0] first, then result[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-014 Transmit handshake:
- In TX_SEND, when tx_busy=0, the block SHALL pulse tx_data_valid for exactly 1 cycle with tx_data stable, then go to TX_WAIT_HIGH.
- In TX_WAIT_HIGH the block SHALL wait for tx_busy=1; in TX_WAIT_LOW it SHALL wait for tx_busy=0.
- After TX_WAIT_LOW the block SHALL send the next byte, or return to IDLE when none remains.
REQ-015 rx_data_valid bytes arriving in RD_WAIT, ALU_WAIT or any TX_* state SHALL be dropped; no buffering is provided.
REQ-016 All outputs SHALL be registered; strobes SHALL never be high for two consecutive cycles.
REQ-017 rf_read_data_valid and alu_result_valid SHALL be ignored outside RD_WAIT and ALU_WAIT respectively.

Reset
REQ-018 While reset=1 at a clk edge, every output SHALL be 0 (including rf_address, rf_write_data, alu_function and tx_data), the state SHALL be IDLE, and the latched response SHALL be cleared.
REQ-019 Reset mid-frame or mid-transmission SHALL abandon the frame with no further strobes; the next frame SHALL start from IDLE.

Structure
REQ-020 A shared package command_frame_pkg SHALL hold the four command codes, the state encoding, and the operand addresses 0 and 1.
REQ-021 The transmit handshake (TX_SEND/TX_WAIT_HIGH/TX_WAIT_LOW and byte count) SHALL be a sub-module named response_sender, taking a 1- or 2-byte payload and a start pulse and returning a done pulse.

Verification
REQ-022 Stimulus AA,05,3C -> rf_write_enable for 1 cycle with rf_address=5 and rf_write_data=0x3C; no tx_data_valid.
REQ-023 Stimulus BB,07, with rf_read_data=0x5A valid 2 cycles later -> rf_read_enable for 1 cycle with rf_address=7; tx_data=0x5A sent once.
REQ-024 Stimulus CC,10,20,02, with alu_result=0x1234 -> writes 0x10@0 and 0x20@1, alu_enable with alu_function=2; tx bytes 0x34 then 0x12, the second only after tx_busy falls.
REQ-025 Stimulus AA,03 followed by a byte with rx_error=1, then AA,03,11 -> no strobe for the first frame; a single write of 0x11@3 for the second.
REQ-026 Stimulus 0x55 in IDLE, then DD,01 with reset asserted during ALU_WAIT -> 0x55 ignored; after reset all outputs are 0 and no tx_data_valid is issued.
